// File: rtl/serial_pkg.sv
// Shared definitions for the serial front end: FSM encoding and default sizes.
package serial_pkg;

    localparam int DEFAULT_WIDTH = 8;
    localparam int DEFAULT_DEPTH = 4;

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_e;

endpackage

// File: rtl/bit_serializer_if.sv
// Word-in / bit-out bundle between a word source and the bit serializer.
interface bit_serializer_if
    import serial_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
);

    logic [WIDTH-1:0] in_data;
    logic             in_valid;
    logic             in_ready;
    logic             ser_bit;
    logic             ser_valid;
    logic             busy;

    modport master (
        output in_data,
        output in_valid,
        input  in_ready,
        input  ser_bit,
        input  ser_valid,
        input  busy
    );

    modport slave (
        input  in_data,
        input  in_valid,
        output in_ready,
        output ser_bit,
        output ser_valid,
        output busy
    );

endinterface

// File: rtl/sync_fifo.sv
// Generic synchronous FIFO with first-word-fall-through read.
module sync_fifo
    import serial_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH,
    parameter int DEPTH = DEFAULT_DEPTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             wr_en,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             rd_en,
    output logic [WIDTH-1:0] rd_data,
    output logic             full,
    output logic             empty
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [AW:0]      count_q, count_d;
    logic             do_wr, do_rd;

    assign do_wr = wr_en && !full;
    assign do_rd = rd_en && !empty;

    // Storage is not reset; only entries below the occupancy count are ever read.
    always_ff @(posedge clk) begin
        if (do_wr) begin
            mem_q[wr_ptr_q] <= wr_data;
        end
    end

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (do_wr) begin
            wr_ptr_d = wr_ptr_q + AW'(1);
        end
        if (do_rd) begin
            rd_ptr_d = rd_ptr_q + AW'(1);
        end
        if (do_wr && !do_rd) begin
            count_d = count_q + (AW+1)'(1);
        end else if (do_rd && !do_wr) begin
            count_d = count_q - (AW+1)'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    assign rd_data = mem_q[rd_ptr_q];
    assign full    = (count_q == (AW+1)'(DEPTH));
    assign empty   = (count_q == '0);

endmodule

// File: rtl/bit_serializer.sv
// Parallel-to-serial front end: buffers words and streams them one bit per clock.
//
//   state | meaning
//   IDLE  | line held at 0, waiting for a queued word
//   SHIFT | emitting the shift register's first-order bit each clock
module bit_serializer
    import serial_pkg::*;
#(
    parameter int WIDTH     = DEFAULT_WIDTH,
    parameter int DEPTH     = DEFAULT_DEPTH,
    parameter bit MSB_FIRST = 1'b1
) (
    input logic             clk,
    input logic             rst,
    bit_serializer_if.slave bus
);

    localparam int            CW       = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST_CNT = CW'(WIDTH - 1);

    state_e           state_q, state_d;
    logic [WIDTH-1:0] sreg_q, sreg_d;
    logic [WIDTH-1:0] sreg_shifted;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] fifo_rd_data;
    logic             fifo_full, fifo_empty;
    logic             push, pop, last_bit;

    assign bus.in_ready = !fifo_full && !rst;
    assign push         = bus.in_valid && bus.in_ready;
    assign last_bit     = (cnt_q == LAST_CNT);
    assign sreg_shifted = MSB_FIRST ? {sreg_q[WIDTH-2:0], 1'b0}
                                    : {1'b0, sreg_q[WIDTH-1:1]};

    sync_fifo #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .wr_en   (push),
        .wr_data (bus.in_data),
        .rd_en   (pop),
        .rd_data (fifo_rd_data),
        .full    (fifo_full),
        .empty   (fifo_empty)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            sreg_q  <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            sreg_q  <= sreg_d;
            cnt_q   <= cnt_d;
        end
    end

    // Reloading on the last bit keeps consecutive words gap-free.
    always_comb begin
        state_d = state_q;
        sreg_d  = sreg_q;
        cnt_d   = cnt_q;
        pop     = 1'b0;
        case (state_q)
            IDLE: begin
                if (!fifo_empty) begin
                    pop     = 1'b1;
                    sreg_d  = fifo_rd_data;
                    cnt_d   = '0;
                    state_d = SHIFT;
                end
            end
            SHIFT: begin
                if (last_bit) begin
                    if (!fifo_empty) begin
                        pop    = 1'b1;
                        sreg_d = fifo_rd_data;
                        cnt_d  = '0;
                    end else begin
                        state_d = IDLE;
                    end
                end else begin
                    sreg_d = sreg_shifted;
                    cnt_d  = cnt_q + CW'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        bus.ser_valid = (state_q == SHIFT);
        bus.ser_bit   = 1'b0;
        if (state_q == SHIFT) begin
            bus.ser_bit = MSB_FIRST ? sreg_q[WIDTH-1] : sreg_q[0];
        end
        bus.busy = (state_q == SHIFT) || !fifo_empty;
    end

endmodule

// File: tb/tb_bit_serializer.sv
// Bench for bit_serializer: MSB-first and LSB-first instances share one stimulus and a timeline model.
module tb_bit_serializer;
    import serial_pkg::*;

    localparam int W = 8;
    localparam int D = 4;

    logic         clk      = 1'b0;
    logic         rst      = 1'b1;
    logic [W-1:0] in_data  = '0;
    logic         in_valid = 1'b0;

    int n_checks = 0;
    int n_fail   = 0;

    bit_serializer_if #(.WIDTH(W)) bus_m ();
    bit_serializer_if #(.WIDTH(W)) bus_l ();

    assign bus_m.in_data  = in_data;
    assign bus_m.in_valid = in_valid;
    assign bus_l.in_data  = in_data;
    assign bus_l.in_valid = in_valid;

    bit_serializer #(.WIDTH(W), .DEPTH(D), .MSB_FIRST(1'b1)) u_dut_msb (
        .clk (clk),
        .rst (rst),
        .bus (bus_m)
    );

    bit_serializer #(.WIDTH(W), .DEPTH(D), .MSB_FIRST(1'b0)) u_dut_lsb (
        .clk (clk),
        .rst (rst),
        .bus (bus_l)
    );

    always #5 clk = ~clk;

    // Timeline model: each accepted word owns the WIDTH intervals after its load edge.
    typedef struct {
        logic [W-1:0] data;
        int           start;
    } word_t;

    word_t wq[$];
    int    edge_n    = 0;
    int    next_free = 0;

    bit    log_m[$];
    bit    log_l[$];
    logic [5:0] det_q = '0;
    int    det_hits  = 0;
    int    v_first   = -1;
    int    v_last    = -1;
    int    blocked   = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (edge %0d)", name, act, exp, edge_n);
        end
    endtask

    task automatic timeout_fail(input string name);
        n_checks++;
        n_fail++;
        $display("FAIL %s: timed out (edge %0d)", name, edge_n);
    endtask

    function automatic logic [63:0] pack(input bit q[$]);
        logic [63:0] v = '0;
        for (int i = 0; i < q.size(); i++) begin
            v = {v[62:0], q[i]};
        end
        return v;
    endfunction

    function automatic int occupancy(input int e);
        int n = 0;
        foreach (wq[i]) begin
            if (wq[i].start > e) n++;
        end
        return n;
    endfunction

    initial begin : model_update
        word_t w;
        forever begin
            @(posedge clk);
            if (rst) begin
                wq.delete();
                next_free = 0;
            end else if (in_valid && occupancy(edge_n) < D) begin
                w.data    = in_data;
                w.start   = (edge_n + 2 > next_free) ? edge_n + 2 : next_free;
                next_free = w.start + W;
                wq.push_back(w);
            end
            edge_n++;
        end
    end

    initial begin : compare
        logic         e_valid;
        logic [W-1:0] e_data;
        logic         e_ready, e_busy, e_bit_m, e_bit_l;
        int           k, occ;
        forever begin
            @(negedge clk);
            if (edge_n > 0) begin
                while (wq.size() > 0 && wq[0].start + W <= edge_n) void'(wq.pop_front());
                e_valid = 1'b0;
                e_data  = '0;
                k       = 0;
                foreach (wq[i]) begin
                    if (wq[i].start <= edge_n && edge_n < wq[i].start + W) begin
                        e_valid = 1'b1;
                        e_data  = wq[i].data;
                        k       = edge_n - wq[i].start;
                    end
                end
                occ     = occupancy(edge_n);
                e_ready = !rst && (occ < D);
                e_busy  = e_valid || (occ > 0);
                e_bit_m = e_valid && e_data[W-1-k];
                e_bit_l = e_valid && e_data[k];
                chk("in_ready_msb",  bus_m.in_ready,  e_ready);
                chk("in_ready_lsb",  bus_l.in_ready,  e_ready);
                chk("ser_valid_msb", bus_m.ser_valid, e_valid);
                chk("ser_valid_lsb", bus_l.ser_valid, e_valid);
                chk("ser_bit_msb",   bus_m.ser_bit,   e_bit_m);
                chk("ser_bit_lsb",   bus_l.ser_bit,   e_bit_l);
                chk("busy_msb",      bus_m.busy,      e_busy);
                chk("busy_lsb",      bus_l.busy,      e_busy);
                if (bus_m.ser_valid === 1'b1) begin
                    log_m.push_back(bus_m.ser_bit);
                    if (v_first < 0) v_first = edge_n;
                    v_last = edge_n;
                end
                if (bus_l.ser_valid === 1'b1) log_l.push_back(bus_l.ser_bit);
                det_q = {det_q[4:0], bus_m.ser_bit};
                if (det_q == 6'b110101) det_hits++;
            end
        end
    end

    // Called at posedge+1; returns at posedge+1 just after the accepting edge.
    task automatic send(input logic [W-1:0] d);
        int t = 0;
        in_data  = d;
        in_valid = 1'b1;
        forever begin
            @(negedge clk);
            t++;
            if (bus_m.in_ready === 1'b1) break;
            blocked++;
            if (t >= 60) break;
        end
        if (t >= 60) timeout_fail("send");
        @(posedge clk);
        #1;
    endtask

    task automatic wait_idle();
        int t = 0;
        in_valid = 1'b0;
        forever begin
            @(negedge clk);
            t++;
            if (bus_m.busy === 1'b0 && bus_l.busy === 1'b0) break;
            if (t >= 200) break;
        end
        if (t >= 200) timeout_fail("wait_idle");
        repeat (2) @(posedge clk);
        #1;
    endtask

    task automatic clear_logs();
        log_m.delete();
        log_l.delete();
        det_hits = 0;
        v_first  = -1;
        v_last   = -1;
        blocked  = 0;
    endtask

    initial begin : stimulus
        int t;
        rst      = 1'b1;
        in_valid = 1'b1;
        in_data  = 8'hFF;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_ser_bit",   bus_m.ser_bit,   1'b0);
        chk("rst_ser_valid", bus_m.ser_valid, 1'b0);
        chk("rst_busy",      bus_m.busy,      1'b0);
        chk("rst_in_ready",  bus_m.in_ready,  1'b0);
        rst      = 1'b0;
        in_valid = 1'b0;
        @(negedge clk);
        chk("ready_after_release", bus_m.in_ready, 1'b1);
        chk("no_word_during_rst",  bus_m.busy,     1'b0);
        @(posedge clk);
        #1;

        clear_logs();
        send(8'b1101_0100);
        wait_idle();
        chk("single_len",  log_m.size(), 8);
        chk("single_bits", pack(log_m),  64'hD4);
        chk("single_det",  det_hits,     1);

        clear_logs();
        send(8'hA5);
        send(8'h3C);
        wait_idle();
        chk("b2b_len",  log_m.size(),         16);
        chk("b2b_bits", pack(log_m),          64'hA53C);
        chk("b2b_span", v_last - v_first + 1, 16);

        clear_logs();
        for (int i = 1; i <= 6; i++) send(W'(i * 8'h11));
        wait_idle();
        chk("full_len",     log_m.size(), 48);
        chk("full_bits",    pack(log_m),  64'h112233445566);
        chk("full_blocked", blocked,      5);

        clear_logs();
        send(8'b0010_1011);
        wait_idle();
        chk("lsb_bits", pack(log_l), 64'hD4);
        chk("msb_bits", pack(log_m), 64'h2B);

        clear_logs();
        send(8'hFF);
        send(8'hAA);
        send(8'h55);
        in_valid = 1'b0;
        t = 0;
        forever begin
            @(negedge clk);
            #1;
            t++;
            if (log_m.size() >= 3 || t >= 40) break;
        end
        if (t >= 40) timeout_fail("mid_wait");
        rst = 1'b1;
        @(posedge clk);
        #1;
        chk("mid_rst_ser_bit", bus_m.ser_bit, 1'b0);
        chk("mid_rst_busy",    bus_m.busy,    1'b0);
        rst = 1'b0;
        repeat (30) @(posedge clk);
        #1;
        chk("mid_rst_len",  log_m.size(), 3);
        chk("mid_rst_bits", pack(log_m),  64'h7);
        chk("mid_rst_idle", bus_m.busy,   1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation did not finish (edge %0d)", edge_n);
        $fatal(1, "watchdog expired");
    end

endmodule
